// File: rtl/rob_ring.sv
// Reorder buffer ring: in-order allocate, out-of-order complete, in-order multi-slot retire.
// Optional build macro ROB_QUERY_BYPASS_EN forwards a same-cycle completion to the operand query port.
module rob_ring #(
  parameter int DEPTH        = 16,
  parameter int VAL_W        = 64,
  parameter int REG_IDX_W    = 5,
  parameter int COMMIT_WIDTH = 2,
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic                            in_clk,
  input  logic                            in_rst_n,
  input  logic                            in_reg_done,
  input  logic [REG_IDX_W-1:0]            in_reg_dst,
  input  logic                            in_reg_set_nzcv,
  output logic                            out_reg_alloc_ready,
  output logic [IDX_W-1:0]                out_reg_alloc_index,
  input  logic                            in_fu_done,
  input  logic [IDX_W-1:0]                in_fu_rob_index,
  input  logic [VAL_W-1:0]                in_fu_value,
  input  logic [3:0]                      in_fu_nzcv,
  input  logic                            in_fu_is_mispred,
  input  logic [VAL_W-1:0]                in_fu_new_pc,
  input  logic [IDX_W-1:0]                in_rs_query_index,
  output logic                            out_rs_query_ready,
  output logic [VAL_W-1:0]                out_rs_query_value,
  output logic [COMMIT_WIDTH-1:0]         out_reg_commit_valid,
  output logic [COMMIT_WIDTH*REG_IDX_W-1:0] out_reg_commit_index,
  output logic [COMMIT_WIDTH*VAL_W-1:0]   out_reg_commit_value,
  output logic [COMMIT_WIDTH-1:0]         out_reg_commit_set_nzcv,
  output logic [COMMIT_WIDTH*4-1:0]       out_reg_commit_nzcv,
  output logic [COMMIT_WIDTH*IDX_W-1:0]   out_reg_commit_rob_index,
  output logic                            out_fetch_mispredict,
  output logic [VAL_W-1:0]                out_fetch_new_pc,
  output logic [IDX_W:0]                  out_count
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]     valid_r;
  logic [DEPTH-1:0]     done_r;
  logic [DEPTH-1:0]     mispred_r;
  logic [DEPTH-1:0]     set_nzcv_r;
  logic [REG_IDX_W-1:0] dst_r   [DEPTH];
  logic [VAL_W-1:0]     value_r [DEPTH];
  logic [VAL_W-1:0]     pc_r    [DEPTH];
  logic [3:0]           nzcv_r  [DEPTH];
  logic [IDX_W-1:0]     head_r;
  logic [IDX_W-1:0]     tail_r;
  logic [IDX_W:0]       count_r;

  logic [COMMIT_WIDTH-1:0] retire_s;
  logic [IDX_W-1:0]        slot_idx_s [COMMIT_WIDTH];
  logic [IDX_W:0]          retire_cnt_s;
  logic [DEPTH-1:0]        retire_mask_s;
  logic                    flush_s;
  logic [VAL_W-1:0]        flush_pc_s;
  logic [IDX_W-1:0]        flush_head_s;
  logic                    stop_s;
  logic                    alloc_ready_s;
  logic                    alloc_fire_s;

  // Retire selection: contiguous done entries from head; a mispredict ends the group.
  always_comb begin
    retire_s      = '0;
    retire_mask_s = '0;
    retire_cnt_s  = '0;
    flush_s       = 1'b0;
    flush_pc_s    = '0;
    flush_head_s  = '0;
    stop_s        = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot_idx_s[k] = head_r + IDX_W'(k);
      if (!stop_s && valid_r[slot_idx_s[k]] && done_r[slot_idx_s[k]]) begin
        retire_s[k]                   = 1'b1;
        retire_mask_s[slot_idx_s[k]]  = 1'b1;
        retire_cnt_s                  = retire_cnt_s + (IDX_W+1)'(1);
        flush_s                       = mispred_r[slot_idx_s[k]];
        stop_s                        = mispred_r[slot_idx_s[k]];
        flush_pc_s                    = pc_r[slot_idx_s[k]];
        flush_head_s                  = slot_idx_s[k] + IDX_W'(1);
      end else begin
        stop_s = 1'b1;
      end
    end
  end

  // Full is judged from registered count only, so same-cycle retires never free a slot early.
  always_comb begin
    alloc_ready_s = (count_r < FULL_CNT);
    alloc_fire_s  = in_reg_done && alloc_ready_s && !flush_s;
  end

  // Head/tail/count pointers; a flush collapses the ring just past the mispredicting entry.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush_s) begin
      head_r  <= flush_head_s;
      tail_r  <= flush_head_s;
      count_r <= '0;
    end else begin
      head_r  <= head_r + retire_cnt_s[IDX_W-1:0];
      tail_r  <= tail_r + IDX_W'(alloc_fire_s);
      count_r <= count_r - retire_cnt_s + (IDX_W+1)'(alloc_fire_s);
    end
  end

  // Entry storage: retire/flush clears, allocation opens, completion fills a live entry.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      valid_r    <= '0;
      done_r     <= '0;
      mispred_r  <= '0;
      set_nzcv_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_r[i]   <= '0;
        value_r[i] <= '0;
        pc_r[i]    <= '0;
        nzcv_r[i]  <= 4'h0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_s || retire_mask_s[i]) begin
          valid_r[i]   <= 1'b0;
          done_r[i]    <= 1'b0;
          mispred_r[i] <= 1'b0;
        end else if (alloc_fire_s && (tail_r == IDX_W'(i))) begin
          valid_r[i]    <= 1'b1;
          done_r[i]     <= 1'b0;
          mispred_r[i]  <= 1'b0;
          dst_r[i]      <= in_reg_dst;
          set_nzcv_r[i] <= in_reg_set_nzcv;
        end else if (in_fu_done && (in_fu_rob_index == IDX_W'(i)) && valid_r[i]) begin
          done_r[i]    <= 1'b1;
          value_r[i]   <= in_fu_value;
          nzcv_r[i]    <= in_fu_nzcv;
          mispred_r[i] <= in_fu_is_mispred;
          pc_r[i]      <= in_fu_new_pc;
        end else begin
          done_r[i] <= done_r[i];
        end
      end
    end
  end

  // Registered commit and redirect outputs; idle slots drive zeros.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_reg_commit_valid     <= '0;
      out_reg_commit_index     <= '0;
      out_reg_commit_value     <= '0;
      out_reg_commit_set_nzcv  <= '0;
      out_reg_commit_nzcv      <= '0;
      out_reg_commit_rob_index <= '0;
      out_fetch_mispredict     <= 1'b0;
      out_fetch_new_pc         <= '0;
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        out_reg_commit_valid[k]                      <= retire_s[k];
        out_reg_commit_index[k*REG_IDX_W +: REG_IDX_W] <= retire_s[k] ? dst_r[slot_idx_s[k]] : '0;
        out_reg_commit_value[k*VAL_W +: VAL_W]       <= retire_s[k] ? value_r[slot_idx_s[k]] : '0;
        out_reg_commit_set_nzcv[k]                   <= retire_s[k] && set_nzcv_r[slot_idx_s[k]];
        out_reg_commit_nzcv[k*4 +: 4]                <= retire_s[k] ? nzcv_r[slot_idx_s[k]] : 4'h0;
        out_reg_commit_rob_index[k*IDX_W +: IDX_W]   <= retire_s[k] ? slot_idx_s[k] : '0;
      end
      out_fetch_mispredict <= flush_s;
      out_fetch_new_pc     <= flush_s ? flush_pc_s : '0;
    end
  end

  // Operand query; the value is zeroed unless the entry is ready.
  always_comb begin
    out_rs_query_ready = valid_r[in_rs_query_index] && done_r[in_rs_query_index];
    out_rs_query_value = out_rs_query_ready ? value_r[in_rs_query_index] : '0;
`ifdef ROB_QUERY_BYPASS_EN
    if (in_fu_done && (in_fu_rob_index == in_rs_query_index)) begin
      out_rs_query_ready = 1'b1;
      out_rs_query_value = in_fu_value;
    end else begin
      out_rs_query_ready = out_rs_query_ready;
    end
`endif
  end

  assign out_reg_alloc_ready = alloc_ready_s;
  assign out_reg_alloc_index = tail_r;
  assign out_count           = count_r;

endmodule

// File: tb/tb_rob_ring.sv
// Directed self-checking bench for rob_ring (DEPTH=16, COMMIT_WIDTH=2).
module tb_rob_ring;
  logic         in_clk = 1'b0;
  logic         in_rst_n;
  logic         in_reg_done;
  logic [4:0]   in_reg_dst;
  logic         in_reg_set_nzcv;
  logic         out_reg_alloc_ready;
  logic [3:0]   out_reg_alloc_index;
  logic         in_fu_done;
  logic [3:0]   in_fu_rob_index;
  logic [63:0]  in_fu_value;
  logic [3:0]   in_fu_nzcv;
  logic         in_fu_is_mispred;
  logic [63:0]  in_fu_new_pc;
  logic [3:0]   in_rs_query_index;
  logic         out_rs_query_ready;
  logic [63:0]  out_rs_query_value;
  logic [1:0]   out_reg_commit_valid;
  logic [9:0]   out_reg_commit_index;
  logic [127:0] out_reg_commit_value;
  logic [1:0]   out_reg_commit_set_nzcv;
  logic [7:0]   out_reg_commit_nzcv;
  logic [7:0]   out_reg_commit_rob_index;
  logic         out_fetch_mispredict;
  logic [63:0]  out_fetch_new_pc;
  logic [4:0]   out_count;

  int n_checks = 0;
  int n_errors = 0;

  rob_ring dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_reg_done(in_reg_done), .in_reg_dst(in_reg_dst), .in_reg_set_nzcv(in_reg_set_nzcv),
    .out_reg_alloc_ready(out_reg_alloc_ready), .out_reg_alloc_index(out_reg_alloc_index),
    .in_fu_done(in_fu_done), .in_fu_rob_index(in_fu_rob_index), .in_fu_value(in_fu_value),
    .in_fu_nzcv(in_fu_nzcv), .in_fu_is_mispred(in_fu_is_mispred), .in_fu_new_pc(in_fu_new_pc),
    .in_rs_query_index(in_rs_query_index), .out_rs_query_ready(out_rs_query_ready),
    .out_rs_query_value(out_rs_query_value),
    .out_reg_commit_valid(out_reg_commit_valid), .out_reg_commit_index(out_reg_commit_index),
    .out_reg_commit_value(out_reg_commit_value), .out_reg_commit_set_nzcv(out_reg_commit_set_nzcv),
    .out_reg_commit_nzcv(out_reg_commit_nzcv), .out_reg_commit_rob_index(out_reg_commit_rob_index),
    .out_fetch_mispredict(out_fetch_mispredict), .out_fetch_new_pc(out_fetch_new_pc),
    .out_count(out_count)
  );

  always #5 in_clk = ~in_clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic complete(input logic [3:0] idx, input logic [63:0] val,
                          input logic mis, input logic [63:0] pc);
    in_fu_done       = 1'b1;
    in_fu_rob_index  = idx;
    in_fu_value      = val;
    in_fu_is_mispred = mis;
    in_fu_new_pc     = pc;
    step();
    in_fu_done       = 1'b0;
    in_fu_is_mispred = 1'b0;
  endtask

  initial begin
    in_rst_n = 1'b0; in_reg_done = 1'b0; in_reg_dst = 5'd0; in_reg_set_nzcv = 1'b0;
    in_fu_done = 1'b0; in_fu_rob_index = 4'd0; in_fu_value = 64'd0; in_fu_nzcv = 4'h0;
    in_fu_is_mispred = 1'b0; in_fu_new_pc = 64'd0; in_rs_query_index = 4'd0;
    step(); step();
    check_eq("rst_ready", out_reg_alloc_ready, 1'b1);
    check_eq("rst_index", out_reg_alloc_index, 4'd0);
    check_eq("rst_count", out_count, 5'd0);
    check_eq("rst_cvalid", out_reg_commit_valid, 2'b00);
    check_eq("rst_mispred", out_fetch_mispredict, 1'b0);
    check_eq("rst_qready", out_rs_query_ready, 1'b0);
    check_eq("rst_qvalue", out_rs_query_value, 64'd0);
    in_rst_n = 1'b1;

    // allocate x1,x2,x3 into entries 0..2
    in_reg_done = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_reg_dst = 5'(i);
      step();
    end
    in_reg_done = 1'b0;
    check_eq("alloc3_count", out_count, 5'd3);
    check_eq("alloc3_index", out_reg_alloc_index, 4'd3);

    // out-of-order completion: entry 1 first, head blocks retirement
    complete(4'd1, 64'h22, 1'b0, 64'd0);
    check_eq("ooo_hold0", out_reg_commit_valid, 2'b00);
    step();
    check_eq("ooo_hold1", out_reg_commit_valid, 2'b00);
    complete(4'd0, 64'h11, 1'b0, 64'd0);
    check_eq("ooo_latency", out_reg_commit_valid, 2'b00);
    step();
    check_eq("pair_valid", out_reg_commit_valid, 2'b11);
    check_eq("pair_dst", out_reg_commit_index, {5'd2, 5'd1});
    check_eq("pair_value", out_reg_commit_value, {64'h22, 64'h11});
    check_eq("pair_robidx", out_reg_commit_rob_index, {4'd1, 4'd0});
    check_eq("pair_count", out_count, 5'd1);
    step();
    check_eq("pair_idle", out_reg_commit_valid, 2'b00);

    // query entry 2 while it completes
    in_rs_query_index = 4'd2;
    in_fu_done = 1'b1; in_fu_rob_index = 4'd2; in_fu_value = 64'hAB;
    #1;
`ifdef ROB_QUERY_BYPASS_EN
    check_eq("q_same_ready", out_rs_query_ready, 1'b1);
    check_eq("q_same_value", out_rs_query_value, 64'hAB);
`else
    check_eq("q_same_ready", out_rs_query_ready, 1'b0);
`endif
    step();
    in_fu_done = 1'b0;
    #1;
    check_eq("q_next_ready", out_rs_query_ready, 1'b1);
    check_eq("q_next_value", out_rs_query_value, 64'hAB);
    step();
    check_eq("q_commit_valid", out_reg_commit_valid, 2'b01);
    check_eq("q_commit_dst", out_reg_commit_index[4:0], 5'd3);
    check_eq("q_commit_value", out_reg_commit_value[63:0], 64'hAB);
    check_eq("q_empty_count", out_count, 5'd0);

    // fill all 16 entries starting at index 3, then a dropped 17th request
    in_reg_done = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_reg_dst = 5'(i);
      step();
    end
    check_eq("full_ready", out_reg_alloc_ready, 1'b0);
    check_eq("full_count", out_count, 5'd16);
    check_eq("full_index", out_reg_alloc_index, 4'd3);
    in_reg_dst = 5'd31;
    step();
    in_reg_done = 1'b0;
    check_eq("drop_count", out_count, 5'd16);
    check_eq("drop_index", out_reg_alloc_index, 4'd3);

    // complete 5, 4, 3; entries 3 and 4 retire together
    complete(4'd5, 64'h55, 1'b0, 64'd0);
    complete(4'd4, 64'h44, 1'b0, 64'd0);
    complete(4'd3, 64'h33, 1'b0, 64'd0);
    in_rs_query_index = 4'd5;
    step();
    check_eq("wrap_valid", out_reg_commit_valid, 2'b11);
    check_eq("wrap_dst", out_reg_commit_index, {5'd1, 5'd0});
    check_eq("wrap_value", out_reg_commit_value, {64'h44, 64'h33});
    check_eq("wrap_count", out_count, 5'd14);
    check_eq("wrap_ready", out_reg_alloc_ready, 1'b1);
    check_eq("pre_rst_q", out_rs_query_ready, 1'b1);

    // asynchronous reset with live entries
    in_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cvalid", out_reg_commit_valid, 2'b00);
    check_eq("mid_rst_cvalue", out_reg_commit_value, 128'd0);
    check_eq("mid_rst_count", out_count, 5'd0);
    check_eq("mid_rst_index", out_reg_alloc_index, 4'd0);
    check_eq("mid_rst_ready", out_reg_alloc_ready, 1'b1);
    check_eq("mid_rst_q", out_rs_query_ready, 1'b0);
    step();
    in_rst_n = 1'b1;
    step();
    check_eq("post_rst_cvalid", out_reg_commit_valid, 2'b00);
    check_eq("post_rst_count", out_count, 5'd0);

    // mispredict: entries 0..3 with dst x4..x7
    in_reg_done = 1'b1;
    for (int i = 4; i <= 7; i++) begin
      in_reg_dst = 5'(i);
      step();
    end
    in_reg_done = 1'b0;
    complete(4'd0, 64'h10, 1'b0, 64'd0);
    step();
    check_eq("mp_first_valid", out_reg_commit_valid, 2'b01);
    check_eq("mp_first_dst", out_reg_commit_index, 10'd4);
    check_eq("mp_first_count", out_count, 5'd3);
    complete(4'd3, 64'h40, 1'b0, 64'd0);
    complete(4'd2, 64'h30, 1'b0, 64'd0);
    complete(4'd1, 64'h20, 1'b1, 64'h400);
    in_reg_done = 1'b1; in_reg_dst = 5'd9;
    step();
    in_reg_done = 1'b0;
    check_eq("mp_valid", out_reg_commit_valid, 2'b01);
    check_eq("mp_dst", out_reg_commit_index, 10'd5);
    check_eq("mp_robidx", out_reg_commit_rob_index, 8'h01);
    check_eq("mp_value", out_reg_commit_value, 128'h20);
    check_eq("mp_pulse", out_fetch_mispredict, 1'b1);
    check_eq("mp_pc", out_fetch_new_pc, 64'h400);
    check_eq("mp_count", out_count, 5'd0);
    check_eq("mp_tail", out_reg_alloc_index, 4'd2);
    step();
    check_eq("mp_pulse_end", out_fetch_mispredict, 1'b0);
    check_eq("mp_no_young", out_reg_commit_valid, 2'b00);
    check_eq("mp_count_end", out_count, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
